// File: rtl/tdc_deco_pkg.sv
// Shared constants and helpers for the TDC stop decoder.
// The error counters are built only when TDC_DECO_ERRCNT_EN is defined.
package tdc_deco_pkg;

  localparam logic EDGE_RISE    = 1'b0;
  localparam logic EDGE_FALL    = 1'b1;
  localparam int   DEF_ONES_LEN = 4;
  localparam int   CNT_W        = 16;

  // Saturating increment: a counter that reached all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/decode_stop_pipe_if.sv
// Sample and result bundle between the stop-column flops, the decoder and the timestamp assembler.
// Valid-only stream: the source presents one snapshot per cycle qualified by wSampleValid, and the
// decoder answers with a wDecoValid pulse per accepted sample; there is no ready and no backpressure.
interface decode_stop_pipe_if #(
  parameter int NUM_FF    = 64,
  parameter int BITS_DECO = 8
);
  import tdc_deco_pkg::*;

  logic [NUM_FF-1:0]    wDecoStopIn;
  logic                 wSampleValid;
  logic                 wEdgeSel;
  logic                 wCntClr;
  logic [BITS_DECO-1:0] wDecoStopOut;
  logic                 wDecoValid;
  logic                 wNoEdge;
  logic                 wMultiEdge;
  logic [CNT_W-1:0]     wNoEdgeCnt;
  logic [CNT_W-1:0]     wMultiEdgeCnt;

  modport master (
    output wDecoStopIn, wSampleValid, wEdgeSel, wCntClr,
    input  wDecoStopOut, wDecoValid, wNoEdge, wMultiEdge, wNoEdgeCnt, wMultiEdgeCnt
  );

  modport slave (
    input  wDecoStopIn, wSampleValid, wEdgeSel, wCntClr,
    output wDecoStopOut, wDecoValid, wNoEdge, wMultiEdge, wNoEdgeCnt, wMultiEdgeCnt
  );

endinterface

// File: rtl/deco_prio_enc.sv
// Combinational priority encoder over the edge-hit vector: highest hit index + 1,
// plus any-hit and multi-hit indications.
module deco_prio_enc #(
  parameter int N_HIT = 60,
  parameter int OUT_W = 8
) (
  input  logic [N_HIT-1:0] hit,
  output logic [OUT_W-1:0] bin,
  output logic             any_hit,
  output logic             multi_hit
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N_HIT; i++) begin
      if (hit[i]) bin = OUT_W'(i + 1);
    end
  end

  assign any_hit   = |hit;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = |(hit & (hit - N_HIT'(1)));

endmodule

// File: rtl/decode_stop_pipe.sv
// Three-stage stop decoder: edge-normalise, bubble-rejecting pattern match, priority encode.
// Optional error counters are built when TDC_DECO_ERRCNT_EN is defined.
module decode_stop_pipe
  import tdc_deco_pkg::*;
#(
  parameter int NUM_FF    = 64,
  parameter int BITS_DECO = 8,
  parameter int ONES_LEN  = DEF_ONES_LEN
) (
  input  logic                wClk,
  input  logic                wRst,
  decode_stop_pipe_if.slave   bus
);

  localparam int N_HIT = NUM_FF - ONES_LEN;

  if (ONES_LEN < 1 || ONES_LEN > 8) begin : g_bad_ones_len
    $error("decode_stop_pipe: ONES_LEN must be in 1..8");
  end
  if (NUM_FF < ONES_LEN + 2) begin : g_bad_num_ff
    $error("decode_stop_pipe: NUM_FF must be at least ONES_LEN+2");
  end
  if ((64'd1 << BITS_DECO) <= 64'(N_HIT)) begin : g_bad_bits_deco
    $error("decode_stop_pipe: BITS_DECO too narrow for NUM_FF-ONES_LEN");
  end

  logic [NUM_FF-1:0]    x_q;
  logic                 v1_q;
  logic [N_HIT-1:0]     hit_d;
  logic [N_HIT-1:0]     hit_q;
  logic                 v2_q;
  logic [BITS_DECO-1:0] enc_bin;
  logic                 enc_any;
  logic                 enc_multi;
  logic [BITS_DECO-1:0] bin_q;
  logic                 dv_q;
  logic                 no_edge_q;
  logic                 multi_q;

  // S1: a falling edge becomes a rising one by inverting the whole snapshot.
  always_ff @(posedge wClk) begin
    x_q <= bus.wDecoStopIn ^ {NUM_FF{bus.wEdgeSel}};
    if (wRst) v1_q <= 1'b0;
    else      v1_q <= bus.wSampleValid;
  end

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N_HIT; i++) begin
      hit_d[i] = ~x_q[i] & (&x_q[i+1 +: ONES_LEN]);
    end
  end

  always_ff @(posedge wClk) begin
    hit_q <= hit_d;
    if (wRst) v2_q <= 1'b0;
    else      v2_q <= v1_q;
  end

  deco_prio_enc #(
    .N_HIT (N_HIT),
    .OUT_W (BITS_DECO)
  ) u_prio_enc (
    .hit       (hit_q),
    .bin       (enc_bin),
    .any_hit   (enc_any),
    .multi_hit (enc_multi)
  );

  // S3: bin holds across bubbles, flags only ever accompany a valid result.
  always_ff @(posedge wClk) begin
    if (wRst) begin
      bin_q     <= '0;
      dv_q      <= 1'b0;
      no_edge_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      dv_q <= v2_q;
      if (v2_q) begin
        bin_q     <= enc_bin;
        no_edge_q <= ~enc_any;
        multi_q   <= enc_multi;
      end else begin
        no_edge_q <= 1'b0;
        multi_q   <= 1'b0;
      end
    end
  end

  assign bus.wDecoStopOut = bin_q;
  assign bus.wDecoValid   = dv_q;
  assign bus.wNoEdge      = no_edge_q;
  assign bus.wMultiEdge   = multi_q;

`ifdef TDC_DECO_ERRCNT_EN
  logic [CNT_W-1:0] no_cnt_q;
  logic [CNT_W-1:0] multi_cnt_q;

  // Counters advance on the same edge that registers the flag, so they line up with it.
  always_ff @(posedge wClk) begin
    if (wRst || bus.wCntClr) begin
      no_cnt_q    <= '0;
      multi_cnt_q <= '0;
    end else begin
      if (v2_q && !enc_any) no_cnt_q    <= sat_inc(no_cnt_q);
      if (v2_q && enc_multi) multi_cnt_q <= sat_inc(multi_cnt_q);
    end
  end

  assign bus.wNoEdgeCnt    = no_cnt_q;
  assign bus.wMultiEdgeCnt = multi_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr    = bus.wCntClr;
  assign bus.wNoEdgeCnt    = '0;
  assign bus.wMultiEdgeCnt = '0;
`endif

endmodule

// File: tb/tb_decode_stop_pipe.sv
// Scoreboard bench for decode_stop_pipe (NUM_FF=16, ONES_LEN=4, BITS_DECO=8); works with or
// without TDC_DECO_ERRCNT_EN defined.
module tb_decode_stop_pipe;
  import tdc_deco_pkg::*;

  localparam int NUM_FF    = 16;
  localparam int BITS_DECO = 8;
  localparam int ONES_LEN  = 4;
  localparam int N_HIT     = NUM_FF - ONES_LEN;
  localparam int EXP_W     = 32 + BITS_DECO + 2;
`ifdef TDC_DECO_ERRCNT_EN
  localparam logic [CNT_W-1:0] SAT_EXP = 16'hFFFF;
`else
  localparam logic [CNT_W-1:0] SAT_EXP = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  decode_stop_pipe_if #(.NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO)) bus ();

  decode_stop_pipe #(
    .NUM_FF    (NUM_FF),
    .BITS_DECO (BITS_DECO),
    .ONES_LEN  (ONES_LEN)
  ) dut (
    .wClk (clk),
    .wRst (rst),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];   // {due_cycle, bin, no_edge, multi}
  logic [CNT_W-1:0] exp_no_cnt    = '0;
  logic [CNT_W-1:0] exp_multi_cnt = '0;
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference decode straight from the pattern definition.
  function automatic logic [BITS_DECO+1:0] ref_decode(input logic [NUM_FF-1:0] data, input logic edge_sel);
    logic [NUM_FF-1:0]    x;
    logic [BITS_DECO-1:0] b;
    int                   hits;
    logic                 ok;
    x    = data ^ {NUM_FF{edge_sel}};
    b    = '0;
    hits = 0;
    for (int i = 0; i < N_HIT; i++) begin
      ok = ~x[i];
      for (int k = 1; k <= ONES_LEN; k++) ok = ok & x[i+k];
      if (ok) begin
        hits++;
        b = BITS_DECO'(i + 1);
      end
    end
    return {b, (hits == 0), (hits > 1)};
  endfunction

  // ---------------- driver tasks (called at a negedge, return at the next) ----------------
  task automatic send_exp(input logic [NUM_FF-1:0] data, input logic edge_sel,
                          input logic [BITS_DECO-1:0] bin, input logic nf, input logic mf);
    bus.wDecoStopIn  = data;
    bus.wEdgeSel     = edge_sel;
    bus.wSampleValid = 1'b1;
    bus.wCntClr      = 1'b0;
    exp_q.push_back({32'(cyc + 3), bin, nf, mf});
    @(negedge clk);
  endtask

  task automatic send_model(input logic [NUM_FF-1:0] data, input logic edge_sel);
    logic [BITS_DECO+1:0] r;
    r = ref_decode(data, edge_sel);
    send_exp(data, edge_sel, r[BITS_DECO+1:2], r[1], r[0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wSampleValid = 1'b0;
      bus.wCntClr      = 1'b0;
      bus.wDecoStopIn  = NUM_FF'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_cnt();
    bus.wSampleValid = 1'b0;
    bus.wCntClr      = 1'b1;
    @(negedge clk);
    bus.wCntClr   = 1'b0;
    exp_no_cnt    = '0;
    exp_multi_cnt = '0;
    check_val("clr_no_cnt", 32'(bus.wNoEdgeCnt), 32'd0);
    check_val("clr_multi_cnt", 32'(bus.wMultiEdgeCnt), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wDecoValid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check_val("latency", 32'(cyc), e[EXP_W-1 -: 32]);
          check_val("bin", 32'(bus.wDecoStopOut), 32'(e[BITS_DECO+1:2]));
          check_val("no_edge", 32'(bus.wNoEdge), 32'(e[1]));
          check_val("multi_edge", 32'(bus.wMultiEdge), 32'(e[0]));
`ifdef TDC_DECO_ERRCNT_EN
          if (e[1] && exp_no_cnt != 16'hFFFF)    exp_no_cnt++;
          if (e[0] && exp_multi_cnt != 16'hFFFF) exp_multi_cnt++;
`endif
          check_val("no_cnt", 32'(bus.wNoEdgeCnt), 32'(exp_no_cnt));
          check_val("multi_cnt", 32'(bus.wMultiEdgeCnt), 32'(exp_multi_cnt));
        end
      end else begin
        check_val("idle_flags", 32'({bus.wNoEdge, bus.wMultiEdge}), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_FF-1:0] t;
    logic              es;
    bus.wDecoStopIn  = '0;
    bus.wSampleValid = 1'b0;
    bus.wEdgeSel     = EDGE_RISE;
    bus.wCntClr      = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_valid", 32'(bus.wDecoValid), 32'd0);
    check_val("rst_bin", 32'(bus.wDecoStopOut), 32'd0);
    check_val("rst_no_edge", 32'(bus.wNoEdge), 32'd0);
    check_val("rst_multi", 32'(bus.wMultiEdge), 32'd0);
    check_val("rst_no_cnt", 32'(bus.wNoEdgeCnt), 32'd0);
    check_val("rst_multi_cnt", 32'(bus.wMultiEdgeCnt), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Directed patterns
    send_exp(16'h00F8, EDGE_RISE, 8'd3, 1'b0, 1'b0);
    idle(2);
    send_exp(16'hFF07, EDGE_FALL, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send_exp(16'h00F8, EDGE_RISE, 8'd3, 1'b0, 1'b0);
      else            send_exp(16'hFF07, EDGE_FALL, 8'd3, 1'b0, 1'b0);
    end
    send_exp(16'h0F78, EDGE_RISE, 8'd8, 1'b0, 1'b1);
    send_exp(16'h0000, EDGE_RISE, 8'd0, 1'b1, 1'b0);
    send_exp(16'hFFFF, EDGE_RISE, 8'd0, 1'b1, 1'b0);
    send_exp(16'hF000, EDGE_RISE, 8'd12, 1'b0, 1'b0);
    send_exp(16'h0FFF, EDGE_FALL, 8'd12, 1'b0, 1'b0);
    send_exp(16'h0FFF, EDGE_RISE, 8'd0, 1'b1, 1'b0);
    idle(1);
    send_exp(16'h1F00, EDGE_RISE, 8'd8, 1'b0, 1'b0);
    drain();

    // Reset mid-flight: A in flight, B presented with reset, C is the first post-reset sample
    send_exp(16'h00F8, EDGE_RISE, 8'd3, 1'b0, 1'b0);
    rst              = 1'b1;
    bus.wDecoStopIn  = 16'hFF07;
    bus.wEdgeSel     = EDGE_FALL;
    bus.wSampleValid = 1'b1;
    exp_q.delete();
    exp_no_cnt       = '0;
    exp_multi_cnt    = '0;
    @(negedge clk);
    rst = 1'b0;
    send_exp(16'hF000, EDGE_RISE, 8'd12, 1'b0, 1'b0);
    drain();
    idle(3);

    // Random thermometer codes with occasional bubbles and gaps
    for (int n = 0; n < 300; n++) begin
      t = '1;
      t = t << $urandom_range(0, NUM_FF);
      if ($urandom_range(0, 3) == 0) t[$urandom_range(0, NUM_FF-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) t = NUM_FF'($urandom);
      es = 1'($urandom_range(0, 1));
      send_model(t ^ {NUM_FF{es}}, es);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Counter saturation and clear
    clear_cnt();
    for (int n = 0; n < 65537; n++) send_exp(16'h0000, EDGE_RISE, 8'd0, 1'b1, 1'b0);
    drain();
    check_val("no_cnt_sat", 32'(bus.wNoEdgeCnt), 32'(SAT_EXP));
    clear_cnt();
    send_exp(16'h0F78, EDGE_RISE, 8'd8, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
